// File: rtl/rwpx_rd_streamer.sv
// Read-side streamer for a circular-buffer block RAM: issues reads behind the
// writer pointer, hides the 1-cycle RAM latency and presents a valid/ready stream.
module rwpx_rd_streamer #(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDRBIT:0]   wptr,
  output logic [ADDRBIT:0]   rptr,
  output logic [ADDRBIT-1:0] ra,
  output logic               re,
  input  logic [WIDTH-1:0]   rdo,
  input  logic               test,
  input  logic               flush,
  output logic               o_vld,
  output logic [WIDTH-1:0]   o_dat,
  input  logic               o_rdy,
  output logic               empty,
  output logic               ovf_err
);

  localparam logic [ADDRBIT:0] DEPTH_P = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT:0] ONE_P   = (ADDRBIT+1)'(1);

  logic [ADDRBIT:0] rptr_r, rptr_nxt_s;
  logic             infl_r;
  logic [1:0]       cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] buf0_r, buf1_r, buf0_nxt_s, buf1_nxt_s;
  logic             ovf_r, ovf_nxt_s;

  logic [ADDRBIT:0] avail_s;
  logic             overrun_s;
  logic             pop_s, pop_eff_s, push_s, issue_s;
  logic [2:0]       occ_s;

  assign avail_s   = wptr - rptr_r;
  assign overrun_s = (avail_s > DEPTH_P);
  assign pop_s     = (cnt_r != 2'd0) & o_rdy;
  // flush wins over pop so the head (and thus o_dat) is left untouched
  assign pop_eff_s = pop_s & ~flush;
  assign push_s    = infl_r & ~flush;
  assign occ_s     = {1'b0, cnt_r} + {2'b00, infl_r} - {2'b00, pop_s};
  // overrun is also gated combinationally so no read slips out before ovf_err registers
  assign issue_s   = (avail_s != '0) & ~test & ~flush & ~ovf_r & ~overrun_s & (occ_s < 3'd2);

  // Next-state for pointer, occupancy, overrun flag and the 2-entry skid buffer
  always_comb begin
    rptr_nxt_s = rptr_r;
    cnt_nxt_s  = cnt_r;
    buf0_nxt_s = buf0_r;
    buf1_nxt_s = buf1_r;
    ovf_nxt_s  = ovf_r | overrun_s;

    if (flush) begin
      rptr_nxt_s = wptr;
      cnt_nxt_s  = 2'd0;
      ovf_nxt_s  = 1'b0;
    end else begin
      if (issue_s) begin
        rptr_nxt_s = rptr_r + ONE_P;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({push_s, pop_eff_s})
        2'b10:   cnt_nxt_s = cnt_r + 2'd1;
        2'b01:   cnt_nxt_s = cnt_r - 2'd1;
        default: cnt_nxt_s = cnt_r;
      endcase
    end

    // buf0 is the head; when the last entry pops it is kept so o_dat holds its value
    case (cnt_r)
      2'd0: begin
        if (push_s) begin
          buf0_nxt_s = rdo;
        end else begin
          buf0_nxt_s = buf0_r;
        end
      end
      2'd1: begin
        if (push_s && pop_eff_s) begin
          buf0_nxt_s = rdo;
        end else if (push_s) begin
          buf1_nxt_s = rdo;
        end else begin
          buf0_nxt_s = buf0_r;
        end
      end
      2'd2: begin
        if (pop_eff_s) begin
          buf0_nxt_s = buf1_r;
        end else begin
          buf0_nxt_s = buf0_r;
        end
        if (push_s) begin
          buf1_nxt_s = rdo;
        end else begin
          buf1_nxt_s = buf1_r;
        end
      end
      default: begin
        buf0_nxt_s = buf0_r;
        buf1_nxt_s = buf1_r;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_r <= '0;
      infl_r <= 1'b0;
      cnt_r  <= 2'd0;
      buf0_r <= '0;
      buf1_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      rptr_r <= rptr_nxt_s;
      infl_r <= issue_s;
      cnt_r  <= cnt_nxt_s;
      buf0_r <= buf0_nxt_s;
      buf1_r <= buf1_nxt_s;
      ovf_r  <= ovf_nxt_s;
    end
  end

  assign rptr    = rptr_r;
  assign ra      = rptr_r[ADDRBIT-1:0];
  assign re      = issue_s;
  assign o_vld   = (cnt_r != 2'd0);
  assign o_dat   = buf0_r;
  assign empty   = (avail_s == '0) & (cnt_r == 2'd0) & ~infl_r;
  assign ovf_err = ovf_r;

endmodule
